// File: rtl/agc_pkg.sv
// Shared widths, offset limits and sequencer state encoding for the AGC loop controller.
package agc_pkg;
   localparam int SCALE_W = 17;
   localparam int OFF_W   = 8;
   localparam int SQ_W    = 24;
   localparam int CNT_W   = 21;
   localparam int STEP_W  = 16;
   localparam int ITER_W  = 16;

   localparam logic signed [OFF_W-1:0] OFF_MIN = 8'sh80;
   localparam logic signed [OFF_W-1:0] OFF_MAX = 8'sh7F;
   localparam logic signed [OFF_W-1:0] OFF_ONE = 8'sh01;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_INIT_APPLY,
      ST_TICK,
      ST_MEASURE,
      ST_SETTLE,
      ST_COMPUTE,
      ST_LOAD,
      ST_APPLY
   } state_e;
endpackage

// File: rtl/agc_loop_ctrl_if.sv
// Bundle between the loop controller (master) and one agc_core (slave).
interface agc_loop_ctrl_if;
   import agc_pkg::*;

   logic                     agc_tick_o;
   logic                     agc_ce_o;
   logic                     agc_rst_o;
   logic [SCALE_W-1:0]       agc_scale_o;
   logic [OFF_W-1:0]         agc_offset_o;
   logic                     agc_scale_ce_o;
   logic                     agc_offset_ce_o;
   logic                     agc_apply_o;
   logic [SQ_W-1:0]          sq_accum_i;
   logic [CNT_W-1:0]         gt_accum_i;
   logic [CNT_W-1:0]         lt_accum_i;

   modport master (
      output agc_tick_o, agc_ce_o, agc_rst_o, agc_scale_o, agc_offset_o,
             agc_scale_ce_o, agc_offset_ce_o, agc_apply_o,
      input  sq_accum_i, gt_accum_i, lt_accum_i
   );

   modport slave (
      input  agc_tick_o, agc_ce_o, agc_rst_o, agc_scale_o, agc_offset_o,
             agc_scale_ce_o, agc_offset_ce_o, agc_apply_o,
      output sq_accum_i, gt_accum_i, lt_accum_i
   );
endinterface

// File: rtl/agc_step_calc.sv
// Combinational scale/offset stepping with saturation; clip_o flags any clamped result.
module agc_step_calc
   import agc_pkg::*;
#(
   parameter logic [SCALE_W-1:0] SCALE_MAX = 17'h1FFFF
) (
   input  logic [SCALE_W-1:0]       scale_i,
   input  logic signed [OFF_W-1:0]  offset_i,
   input  logic [SQ_W-1:0]          sq_i,
   input  logic [SQ_W-1:0]          target_i,
   input  logic [SQ_W-1:0]          deadband_i,
   input  logic [STEP_W-1:0]        step_i,
   input  logic [CNT_W-1:0]         thresh_i,
   input  logic [CNT_W-1:0]         gt_i,
   input  logic [CNT_W-1:0]         lt_i,
   output logic [SCALE_W-1:0]       scale_o,
   output logic signed [OFF_W-1:0]  offset_o,
   output logic                     clip_o
);
   // Each helper returns {clip, value}.
   function automatic logic [SCALE_W:0] scale_down(input logic [SCALE_W-1:0] s,
                                                   input logic [STEP_W-1:0]  st);
      logic [SCALE_W:0] se, ste;
      se  = {1'b0, s};
      ste = (SCALE_W+1)'(st);
      if (ste > se) return {1'b1, {SCALE_W{1'b0}}};
      return se - ste;
   endfunction

   function automatic logic [SCALE_W:0] scale_up(input logic [SCALE_W-1:0] s,
                                                 input logic [STEP_W-1:0]  st);
      logic [SCALE_W:0] sum;
      sum = {1'b0, s} + (SCALE_W+1)'(st);
      if (sum > {1'b0, SCALE_MAX}) return {1'b1, SCALE_MAX};
      return sum;
   endfunction

   function automatic logic [OFF_W:0] off_down(input logic signed [OFF_W-1:0] o);
      if (o == OFF_MIN) return {1'b1, o};
      return {1'b0, o - OFF_ONE};
   endfunction

   function automatic logic [OFF_W:0] off_up(input logic signed [OFF_W-1:0] o);
      if (o == OFF_MAX) return {1'b1, o};
      return {1'b0, o + OFF_ONE};
   endfunction

   logic [SQ_W:0]          sq_ext, band_hi, band_lo;
   logic signed [CNT_W:0]  diff, thr;
   logic [SCALE_W:0]       sc_res;
   logic [OFF_W:0]         of_res;

   // Lower band edge floors at zero; upper edge keeps its carry.
   assign sq_ext  = {1'b0, sq_i};
   assign band_hi = {1'b0, target_i} + {1'b0, deadband_i};
   assign band_lo = (target_i >= deadband_i) ? {1'b0, target_i - deadband_i} : '0;
   assign diff    = $signed({1'b0, gt_i}) - $signed({1'b0, lt_i});
   assign thr     = $signed({1'b0, thresh_i});

   always_comb begin
      sc_res = {1'b0, scale_i};
      of_res = {1'b0, offset_i};
      if (sq_ext > band_hi)      sc_res = scale_down(scale_i, step_i);
      else if (sq_ext < band_lo) sc_res = scale_up(scale_i, step_i);
      if (diff > thr)            of_res = off_down(offset_i);
      else if (diff < -thr)      of_res = off_up(offset_i);
   end

   assign scale_o  = sc_res[SCALE_W-1:0];
   assign offset_o = of_res[OFF_W-1:0];
   assign clip_o   = sc_res[SCALE_W] | of_res[OFF_W];
endmodule

// File: rtl/agc_loop_ctrl.sv
// Closed-loop AGC sequencer: measure, settle, step scale/offset, load and apply, repeat.
module agc_loop_ctrl
   import agc_pkg::*;
#(
   parameter int unsigned        MEAS_CYCLES   = 131072,
   parameter int unsigned        SETTLE_CYCLES = 6,
   parameter logic [SCALE_W-1:0] SCALE_MAX     = 17'h1FFFF
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     enable_i,
   input  logic                     oneshot_i,
   input  logic [SCALE_W-1:0]       init_scale_i,
   input  logic signed [OFF_W-1:0]  init_offset_i,
   input  logic [SQ_W-1:0]          target_sq_i,
   input  logic [SQ_W-1:0]          deadband_i,
   input  logic [STEP_W-1:0]        scale_step_i,
   input  logic [CNT_W-1:0]         offset_thresh_i,
   agc_loop_ctrl_if.master          core,
   output logic                     busy_o,
   output logic                     iter_done_o,
   output logic                     sat_o,
   output logic [ITER_W-1:0]        iter_count_o
);
   localparam int unsigned TMR_MAX = (MEAS_CYCLES > SETTLE_CYCLES) ? MEAS_CYCLES : SETTLE_CYCLES;
   localparam int          TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] MEAS_LAST   = TMR_W'(MEAS_CYCLES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

   state_e                    state_q, state_d;
   logic [TMR_W-1:0]          tmr_q, tmr_d;
   logic                      oneshot_q, oneshot_d;
   logic [SCALE_W-1:0]        scale_q, scale_d;
   logic signed [OFF_W-1:0]   offset_q, offset_d;
   logic                      sat_q, sat_d;
   logic [ITER_W-1:0]         iter_q, iter_d;
   logic rst_q, rst_d, tick_q, tick_d, ce_q, ce_d, ld_q, ld_d;
   logic apply_q, apply_d, done_q, done_d, busy_q, busy_d;

   logic [SCALE_W-1:0]        calc_scale;
   logic signed [OFF_W-1:0]   calc_offset;
   logic                      calc_clip;

   agc_step_calc #(.SCALE_MAX(SCALE_MAX)) u_step (
      .scale_i    (scale_q),
      .offset_i   (offset_q),
      .sq_i       (core.sq_accum_i),
      .target_i   (target_sq_i),
      .deadband_i (deadband_i),
      .step_i     (scale_step_i),
      .thresh_i   (offset_thresh_i),
      .gt_i       (core.gt_accum_i),
      .lt_i       (core.lt_accum_i),
      .scale_o    (calc_scale),
      .offset_o   (calc_offset),
      .clip_o     (calc_clip)
   );

   // Registered outputs are decoded from the next state, so each strobe lines up with its state.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      oneshot_d = oneshot_q;
      scale_d   = scale_q;
      offset_d  = offset_q;
      sat_d     = sat_q;
      iter_d    = iter_q;
      case (state_q)
         ST_IDLE: if (enable_i | oneshot_i) begin
            state_d   = ST_INIT;
            oneshot_d = ~enable_i;
            iter_d    = '0;
            sat_d     = 1'b0;
            scale_d   = init_scale_i;
            offset_d  = init_offset_i;
         end
         ST_INIT:       state_d = ST_INIT_APPLY;
         ST_INIT_APPLY: state_d = ST_TICK;
         ST_TICK: begin
            state_d = ST_MEASURE;
            tmr_d   = '0;
         end
         ST_MEASURE: if (tmr_q == MEAS_LAST) begin
            state_d = ST_SETTLE;
            tmr_d   = '0;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
         // Accumulators are valid at the end of the settle wait; results show during COMPUTE.
         ST_SETTLE: if (tmr_q == SETTLE_LAST) begin
            state_d  = ST_COMPUTE;
            scale_d  = calc_scale;
            offset_d = calc_offset;
            sat_d    = sat_q | calc_clip;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
         ST_COMPUTE: state_d = ST_LOAD;
         ST_LOAD: begin
            state_d = ST_APPLY;
            iter_d  = iter_q + 1'b1;
         end
         ST_APPLY: state_d = (enable_i & ~oneshot_q) ? ST_TICK : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      rst_d   = (state_d == ST_INIT);
      tick_d  = (state_d == ST_TICK);
      ce_d    = (state_d == ST_MEASURE);
      ld_d    = (state_d == ST_INIT) || (state_d == ST_LOAD);
      apply_d = (state_d == ST_INIT_APPLY) || (state_d == ST_APPLY);
      done_d  = (state_d == ST_APPLY);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge aclk) begin
      tmr_q <= tmr_d;
      if (!aresetn) begin
         state_q   <= ST_IDLE;
         oneshot_q <= 1'b0;
         scale_q   <= '0;
         offset_q  <= '0;
         sat_q     <= 1'b0;
         iter_q    <= '0;
         rst_q     <= 1'b0;
         tick_q    <= 1'b0;
         ce_q      <= 1'b0;
         ld_q      <= 1'b0;
         apply_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         oneshot_q <= oneshot_d;
         scale_q   <= scale_d;
         offset_q  <= offset_d;
         sat_q     <= sat_d;
         iter_q    <= iter_d;
         rst_q     <= rst_d;
         tick_q    <= tick_d;
         ce_q      <= ce_d;
         ld_q      <= ld_d;
         apply_q   <= apply_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign core.agc_rst_o      = rst_q;
   assign core.agc_tick_o     = tick_q;
   assign core.agc_ce_o       = ce_q;
   assign core.agc_scale_o    = scale_q;
   assign core.agc_offset_o   = offset_q;
   assign core.agc_scale_ce_o = ld_q;
   assign core.agc_offset_ce_o = ld_q;
   assign core.agc_apply_o    = apply_q;
   assign busy_o              = busy_q;
   assign iter_done_o         = done_q;
   assign sat_o               = sat_q;
   assign iter_count_o        = iter_q;
endmodule
